// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared FSM state type and RV32I load/store funct3 encodings.
// Revision : 1.0
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Load lane extraction/extension, store lane merge, access errors.
// Revision : 1.0
// ============================================================================
module lsu_align
  import mem_pkg::*;
(
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o,
  output logic        err_o
);

  logic [4:0]  shamt;
  logic [15:0] lane;

  // Shifting the whole word down by the byte offset puts the addressed lane at bit 0.
  assign shamt = {offset_i, 3'b000};
  assign lane  = 16'(word_i >> shamt);

  always_comb begin
    load_data_o  = '0;
    store_word_o = word_i;
    err_o        = 1'b0;
    if (mem_rd_i && mem_wr_i) begin
      err_o = 1'b1;
    end else if (mem_rd_i) begin
      case (funct3_i)
        LB:  load_data_o = {{24{lane[7]}}, lane[7:0]};
        LBU: load_data_o = {24'd0, lane[7:0]};
        LH: begin
          if (offset_i[0]) err_o = 1'b1;
          else             load_data_o = {{16{lane[15]}}, lane};
        end
        LHU: begin
          if (offset_i[0]) err_o = 1'b1;
          else             load_data_o = {16'd0, lane};
        end
        LW: begin
          if (offset_i != 2'b00) err_o = 1'b1;
          else                   load_data_o = word_i;
        end
        default: err_o = 1'b1;
      endcase
    end else if (mem_wr_i) begin
      case (funct3_i)
        SB: store_word_o = (word_i & ~(32'h0000_00FF << shamt))
                         | ({24'd0, wdata_i[7:0]} << shamt);
        SH: begin
          if (offset_i[0]) err_o = 1'b1;
          else store_word_o = (word_i & ~(32'h0000_FFFF << shamt))
                            | ({16'd0, wdata_i[15:0]} << shamt);
        end
        SW: begin
          if (offset_i != 2'b00) err_o = 1'b1;
          else                   store_word_o = wdata_i;
        end
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Fixed-latency word-organised data memory with RV32I sized access.
// Revision : 1.0
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWr,
  input  logic [11:0] addr,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  output logic        rsp_valid,
  output logic [31:0] data_read,
  output logic        rsp_err
);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] data_read_q;
  logic        rd_q;
  logic        wr_q;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_q [NUM_WORDS];

  logic        in_idle;
  logic        accept;
  logic        enter_resp;
  logic        sel_rd;
  logic        sel_wr;
  logic [2:0]  sel_f3;
  logic [11:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [9:0]  word_idx;
  logic        range_err;
  logic [31:0] word_rd;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        align_err;
  logic        acc_err;
  logic [31:0] data_read_d;

  assign in_idle    = (state_q == IDLE);
  assign accept     = in_idle && req_valid && (MemRead || MemWr);
  assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd1));

  // With LATENCY 1 the access completes on its own accept edge, so use the live inputs.
  assign sel_rd    = in_idle ? MemRead    : rd_q;
  assign sel_wr    = in_idle ? MemWr      : wr_q;
  assign sel_f3    = in_idle ? funct3     : funct3_q;
  assign sel_addr  = in_idle ? addr       : addr_q;
  assign sel_wdata = in_idle ? write_data : wdata_q;

  assign word_idx  = sel_addr[11:2];
  assign range_err = (32'(word_idx) >= NUM_WORDS);
  assign word_rd   = range_err ? 32'd0 : mem_q[word_idx];
  assign acc_err   = align_err || range_err;

  assign data_read_d = (sel_rd && !acc_err) ? load_data : 32'd0;

  lsu_align u_lsu_align (
    .mem_rd_i     (sel_rd),
    .mem_wr_i     (sel_wr),
    .funct3_i     (sel_f3),
    .offset_i     (sel_addr[1:0]),
    .word_i       (word_rd),
    .wdata_i      (sel_wdata),
    .load_data_o  (load_data),
    .store_word_o (store_word),
    .err_o        (align_err)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) mem_q[i] <= '0;
    end else if (enter_resp && sel_wr && !acc_err) begin
      mem_q[word_idx] <= store_word;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      data_read_q <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp && acc_err;
      data_read_q <= enter_resp ? data_read_d : 32'd0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rd_q        <= MemRead;
            wr_q        <= MemWr;
            funct3_q    <= funct3;
            addr_q      <= addr;
            wdata_q     <= write_data;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign data_read = data_read_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench with directed, random and LATENCY=1 streaming.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        req_valid, MemRead, MemWr, req_ready, rsp_valid, rsp_err;
  logic [11:0] addr;
  logic [31:0] write_data, data_read;
  logic [2:0]  funct3;

  logic        req_valid1, MemRead1, MemWr1, req_ready1, rsp_valid1, rsp_err1;
  logic [11:0] addr1;
  logic [31:0] write_data1, data_read1;
  logic [2:0]  funct31;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [2][1024];

  data_mem_responder #(.NUM_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWr(MemWr), .addr(addr), .write_data(write_data),
    .funct3(funct3), .rsp_valid(rsp_valid), .data_read(data_read), .rsp_err(rsp_err)
  );

  data_mem_responder #(.NUM_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .MemRead(MemRead1), .MemWr(MemWr1), .addr(addr1), .write_data(write_data1),
    .funct3(funct31), .rsp_valid(rsp_valid1), .data_read(data_read1), .rsp_err(rsp_err1)
  );

  // Reference: byte-addressed memory semantics computed with plain arithmetic.
  function automatic void model_access(input int s, input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [11:0] a,
                                       input logic [31:0] wd,
                                       output logic [31:0] d, output logic e);
    longint unsigned w, val, mask;
    int size, off, idx;
    bit sgn;
    idx  = int'(a) / 4;
    off  = int'(a) % 4;
    w    = 64'(model_mem[s][idx]);
    d    = '0;
    e    = 1'b0;
    size = 0;
    sgn  = 1'b0;
    if (rd && wr) e = 1'b1;
    else if (rd) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: e = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: e = 1'b1;
      endcase
    end
    if (size != 0 && (off % size) != 0) e = 1'b1;
    if (!e && rd) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      val  = (w >> (8 * off)) & mask;
      if (sgn && val >= (mask + 64'd1) / 2) val = val + 64'h1_0000_0000 - (mask + 64'd1);
      d = val[31:0];
    end else if (!e && wr) begin
      mask = ((64'd1 << (8 * size)) - 64'd1) << (8 * off);
      w    = (w & ~mask) | ((64'(wd) << (8 * off)) & mask);
      model_mem[s][idx] = w[31:0];
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) model_mem[s][i] = '0;
  endfunction

  // Drives one access into the LATENCY=2 instance; lat = -1 if no response appears.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] d, output logic e,
                        output logic vnext);
    int guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; MemRead = rd; MemWr = wr; funct3 = f3; addr = a; write_data = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; MemRead = 1'b0; MemWr = 1'b0;
    lat = -1; d = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid === 1'b1) begin lat = k; d = data_read; e = rsp_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vnext = rsp_valid;
  endtask

  // Outside a response strobe the data/error outputs must be held low.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      vectors++;
      if (rsp_valid !== 1'b1 && (data_read !== 32'd0 || rsp_err !== 1'b0)) begin
        miscompares++;
        $display("FAIL idle_outputs dut got data=%h err=%b exp 0/0", data_read, rsp_err);
      end
      if (rsp_valid1 !== 1'b1 && (data_read1 !== 32'd0 || rsp_err1 !== 1'b0)) begin
        miscompares++;
        $display("FAIL idle_outputs dut1 got data=%h err=%b exp 0/0", data_read1, rsp_err1);
      end
    end
  end

  task automatic test_reset();
    n_rst = 1'b0;
    req_valid = 0; MemRead = 0; MemWr = 0; addr = '0; write_data = '0; funct3 = '0;
    req_valid1 = 0; MemRead1 = 0; MemWr1 = 0; addr1 = '0; write_data1 = '0; funct31 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || data_read !== 32'd0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h e=%b exp 1/0/0/0",
               req_ready, rsp_valid, data_read, rsp_err);
    end
    vectors++;
    if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state1 got rdy=%b v=%b exp 1/0", req_ready1, rsp_valid1);
    end
    n_rst = 1'b1;
  endtask

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] xd;
    logic        xe;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [15] = '{
      '{1'b0, 1'b1, 3'd2, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0},
      '{1'b1, 1'b0, 3'd2, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 1'b0, 3'd0, 12'h013, 32'h0,        32'hFFFFFFDE, 1'b0},
      '{1'b1, 1'b0, 3'd4, 12'h013, 32'h0,        32'h000000DE, 1'b0},
      '{1'b1, 1'b0, 3'd1, 12'h010, 32'h0,        32'hFFFFBEEF, 1'b0},
      '{1'b1, 1'b0, 3'd5, 12'h012, 32'h0,        32'h0000DEAD, 1'b0},
      '{1'b0, 1'b1, 3'd0, 12'h011, 32'h00000055, 32'h00000000, 1'b0},
      '{1'b1, 1'b0, 3'd2, 12'h010, 32'h0,        32'hDEAD55EF, 1'b0},
      '{1'b1, 1'b0, 3'd2, 12'h012, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 1'b1, 3'd1, 12'h001, 32'h0000ABCD, 32'h00000000, 1'b1},
      '{1'b1, 1'b0, 3'd2, 12'h000, 32'h0,        32'h00000000, 1'b0},
      '{1'b1, 1'b1, 3'd2, 12'h000, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, 1'b0, 3'd3, 12'h010, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 1'b1, 3'd4, 12'h010, 32'h11111111, 32'h00000000, 1'b1},
      '{1'b1, 1'b0, 3'd2, 12'h010, 32'h0,        32'hDEAD55EF, 1'b0}
    };
    int lat;
    logic [31:0] d, md;
    logic e, me, vn;
    for (int i = 0; i < 15; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, d, e, vn);
      model_access(0, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, md, me);
      vectors++;
      if (lat !== 2 || vn !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_latency[%0d] got lat=%0d next_valid=%b exp 2/0", i, lat, vn);
      end
      vectors++;
      if (d !== tbl[i].xd || e !== tbl[i].xe) begin
        miscompares++;
        $display("FAIL dir_result[%0d] got d=%h e=%b exp d=%h e=%b", i, d, e, tbl[i].xd, tbl[i].xe);
      end
    end
  endtask

  task automatic test_nop_ignored();
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWr = 1'b0; addr = 12'h010; funct3 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL nop_ignored[%0d] got rdy=%b v=%b exp 1/0", i, req_ready, rsp_valid);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    int lat, r;
    logic rd, wr, e, me, vn;
    logic [2:0] f3;
    logic [11:0] a;
    logic [31:0] wd, d, md;
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 9));
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
      wd = $urandom;
      access(rd, wr, f3, a, wd, lat, d, e, vn);
      model_access(0, rd, wr, f3, a, wd, md, me);
      vectors++;
      if (lat !== 2 || d !== md || e !== me) begin
        miscompares++;
        $display("FAIL rand[%0d] rd=%b wr=%b f3=%0d a=%h got lat=%0d d=%h e=%b exp lat=2 d=%h e=%b",
                 i, rd, wr, f3, a, lat, d, e, md, me);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xd;
    logic xe;
    xd = '0; xe = 1'b0;
    @(negedge clk);
    req_valid1 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      vectors++;
      if (req_ready1 !== (cyc % 2 == 0) || rsp_valid1 !== (cyc % 2 == 1)) begin
        miscompares++;
        $display("FAIL b2b_handshake[%0d] got rdy=%b v=%b exp %b/%b",
                 cyc, req_ready1, rsp_valid1, (cyc % 2 == 0), (cyc % 2 == 1));
      end
      if (cyc % 2 == 1) begin
        vectors++;
        if (data_read1 !== xd || rsp_err1 !== xe) begin
          miscompares++;
          $display("FAIL b2b_result[%0d] got d=%h e=%b exp d=%h e=%b", cyc, data_read1, rsp_err1, xd, xe);
        end
      end
      MemWr1      = 1'($urandom_range(0, 1));
      MemRead1    = MemWr1 ? ($urandom_range(0, 7) == 0) : 1'b1;
      funct31     = 3'($urandom_range(0, 5));
      addr1       = 12'($urandom_range(0, 15));
      write_data1 = $urandom;
      if (cyc % 2 == 0)
        model_access(1, MemRead1, MemWr1, funct31, addr1, write_data1, xd, xe);
      @(negedge clk);
    end
    req_valid1 = 1'b0; MemRead1 = 1'b0; MemWr1 = 1'b0;
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [31:0] d;
    logic e, vn;
    @(negedge clk);
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWr = 1'b1; funct3 = 3'd2;
    addr = 12'h020; write_data = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0; MemWr = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset_async got rdy=%b v=%b exp 1/0", req_ready, rsp_valid);
    end
    model_clear();
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_after_release[%0d] got rdy=%b v=%b exp 1/0", i, req_ready, rsp_valid);
      end
    end
    access(1'b1, 1'b0, 3'd2, 12'h020, 32'h0, lat, d, e, vn);
    vectors++;
    if (lat !== 2 || d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_load20 got lat=%0d d=%h e=%b exp 2/00000000/0", lat, d, e);
    end
    access(1'b1, 1'b0, 3'd2, 12'h010, 32'h0, lat, d, e, vn);
    vectors++;
    if (lat !== 2 || d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_load10_cleared got lat=%0d d=%h e=%b exp 2/00000000/0", lat, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_nop_ignored();
    test_random();
    test_back_to_back();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
